// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and helpers for the instruction fetch unit.
// Holds the fetch FSM state encoding, the RV32 opcodes that predecode
// recognises, and the J/B immediate extraction used for redirect targets.
package fetch_pkg;

    // Fetch sequencer states; at most one memory request is ever outstanding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Major opcodes (instr[6:0]) of interest to predecode.
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Width of the WAIT-state timeout counter; covers TIMEOUT_CYCLES up to 255.
    localparam int unsigned TIMER_W = 8;

    // Sign-extended J-type immediate from instr[31:12].
    // Field order in the encoding: imm[20|10:1|11|19:12].
    function automatic logic [31:0] j_imm(input logic [19:0] hi);
        logic [20:0] imm;
        imm = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
        return {{11{imm[20]}}, imm};
    endfunction

    // Sign-extended B-type immediate from instr[31:25] and instr[11:7].
    // Field order in the encoding: imm[12|10:5] ... imm[4:1|11].
    function automatic logic [31:0] b_imm(input logic [6:0] hi, input logic [4:0] lo);
        logic [12:0] imm;
        imm = {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
        return {{19{imm[12]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode -- combinational predecode of a held instruction.
// Flags JAL as a jump candidate and backward conditional branches (sign bit
// of the B-immediate set, i.e. predicted taken) as branch candidates, and
// computes both redirect targets relative to the instruction's address.
module fetch_predecode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic        jump_cand,
    output logic        branch_cand,
    output logic [31:0] jump_target,
    output logic [31:0] branch_target
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];

    // Classify the opcode and form both candidate targets (wrap modulo 2^32).
    always_comb begin
        jump_cand     = 1'b0;
        branch_cand   = 1'b0;
        jump_target   = instr_pc + j_imm(instr[31:12]);
        branch_target = instr_pc + b_imm(instr[31:25], instr[11:7]);
        if (opcode == OPC_JAL) begin
            jump_cand = 1'b1;
        end else if (opcode == OPC_BRANCH && instr[31]) begin
            branch_cand = 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- single-outstanding instruction fetch sequencer.
// Issues one read per program-counter value, waits for the response with a
// timeout, holds the fetched word until the decoder accepts it, and (when
// built with FETCH_PREDECODE_EN defined) emits a one-cycle jump or
// predicted-taken branch redirect on the handoff cycle.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        branch,
    output logic        jump,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic        fetch_err
);

    // Timer value seen on the last permitted WAIT cycle.
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t       state;
    logic [TIMER_W-1:0] timer;

    // Fetch sequencer: all outputs registered; rvalid only honoured in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_err   <= 1'b0;
            timer       <= '0;
        end else begin
            fetch_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pc[1:0] == 2'b00) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end else begin
                        fetch_err <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ready) begin
                        imem_req <= 1'b0;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end else if (timer == TIMEOUT_LAST) begin
                        // Reissue the same address; imem_addr is left untouched.
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PREDECODE_EN
    logic        handoff;
    logic        jump_cand;
    logic        branch_cand;
    logic [31:0] jump_tgt_raw;
    logic [31:0] branch_tgt_raw;

    assign handoff = (state == S_HOLD) && instr_ready;

    fetch_predecode u_predecode (
        .instr         (instr),
        .instr_pc      (instr_pc),
        .jump_cand     (jump_cand),
        .branch_cand   (branch_cand),
        .jump_target   (jump_tgt_raw),
        .branch_target (branch_tgt_raw)
    );

    // Redirects fire only on the handoff cycle; targets read zero otherwise.
    always_comb begin
        jump          = handoff && jump_cand;
        branch        = handoff && branch_cand && !jump_cand;
        jump_target   = jump   ? jump_tgt_raw   : '0;
        branch_target = branch ? branch_tgt_raw : '0;
    end
`else
    // Predecode not built: redirect outputs are constant zero.
    assign jump          = 1'b0;
    assign branch        = 1'b0;
    assign jump_target   = '0;
    assign branch_target = '0;
`endif

endmodule
